// File: rtl/readout_scheduler.sv
// Row-by-row readout sequencer between the sensor FSM and the output buffer.
// Optional watchdog on the buffer handshake is enabled by defining READOUT_TIMEOUT_EN.
module readout_scheduler #(
    parameter int unsigned PIXEL_ARRAY_HEIGHT = 2,
    parameter int unsigned SETTLE_CYCLES      = 1,
    parameter int unsigned BURST_CYCLES       = 4,
    parameter int unsigned ACK_TIMEOUT        = 4,
    localparam int unsigned INDEX_WIDTH  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
    localparam int unsigned SETTLE_WIDTH = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          START,
    input  logic                          ABORT,
    input  logic                          BUFFER_BUSY,
    output logic [PIXEL_ARRAY_HEIGHT-1:0] ROW_SELECT,
    output logic [INDEX_WIDTH-1:0]        ROW_INDEX,
    output logic                          SET_BUFFER,
    output logic                          READY,
    output logic                          FRAME_DONE,
    output logic                          ERROR
);

    if (PIXEL_ARRAY_HEIGHT == 0 || SETTLE_CYCLES == 0 || BURST_CYCLES == 0 || ACK_TIMEOUT == 0) begin : g_bad_params
        $error("readout_scheduler: all parameters must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, SETTLE, LOAD, ACK, DRAIN, DONE} state_t;

    state_t                          state, state_next;
    logic [SETTLE_WIDTH-1:0]         settle_cnt, settle_next;
    logic [INDEX_WIDTH-1:0]          index_next;
    logic [PIXEL_ARRAY_HEIGHT-1:0]   select_next;
    logic                            set_next, ready_next, done_next;

`ifdef READOUT_TIMEOUT_EN
    localparam int unsigned DRAIN_LIMIT = BURST_CYCLES + 2;
    localparam int unsigned WD_MAX      = (ACK_TIMEOUT > DRAIN_LIMIT) ? ACK_TIMEOUT : DRAIN_LIMIT;
    localparam int unsigned WD_WIDTH    = $clog2(WD_MAX + 1);

    logic [WD_WIDTH-1:0] wd_cnt, wd_next;
    logic                error_q, error_next;

    assign ERROR = error_q;
`else
    assign ERROR = 1'b0;
`endif

    // Next-state, counters and next registered outputs
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        index_next  = ROW_INDEX;
`ifdef READOUT_TIMEOUT_EN
        wd_next     = wd_cnt;
        error_next  = error_q;
`endif
        case (state)
            IDLE: begin
                if (START && !ABORT) begin
                    state_next  = SETTLE;
                    index_next  = '0;
                    settle_next = '0;
`ifdef READOUT_TIMEOUT_EN
                    error_next  = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_WIDTH'(SETTLE_CYCLES - 1)) begin
                    state_next = LOAD;
                end else begin
                    settle_next = settle_cnt + SETTLE_WIDTH'(1);
                end
            end
            LOAD: begin
                state_next = ACK;
`ifdef READOUT_TIMEOUT_EN
                wd_next    = '0;
`endif
            end
            ACK: begin
                if (BUFFER_BUSY) begin
                    state_next = DRAIN;
`ifdef READOUT_TIMEOUT_EN
                    wd_next    = '0;
                end else if (wd_cnt >= WD_WIDTH'(ACK_TIMEOUT)) begin
                    state_next = IDLE;
                    error_next = 1'b1;
                end else begin
                    wd_next = wd_cnt + WD_WIDTH'(1);
`endif
                end
            end
            DRAIN: begin
                if (!BUFFER_BUSY) begin
                    if (ROW_INDEX == INDEX_WIDTH'(PIXEL_ARRAY_HEIGHT - 1)) begin
                        state_next = DONE;
                    end else begin
                        state_next  = SETTLE;
                        index_next  = ROW_INDEX + INDEX_WIDTH'(1);
                        settle_next = '0;
                    end
`ifdef READOUT_TIMEOUT_EN
                end else if (wd_cnt >= WD_WIDTH'(DRAIN_LIMIT)) begin
                    state_next = IDLE;
                    error_next = 1'b1;
                end else begin
                    wd_next = wd_cnt + WD_WIDTH'(1);
`endif
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Abort wins over every other transition and leaves index and error untouched
        if (ABORT && state != IDLE) begin
            state_next = IDLE;
            index_next = ROW_INDEX;
`ifdef READOUT_TIMEOUT_EN
            error_next = error_q;
`endif
        end

        select_next = (state_next == SETTLE || state_next == LOAD || state_next == ACK)
                    ? (PIXEL_ARRAY_HEIGHT'(1) << index_next) : '0;
        set_next    = (state_next == LOAD);
        ready_next  = (state_next == IDLE);
        done_next   = (state_next == DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            settle_cnt <= '0;
            ROW_SELECT <= '0;
            ROW_INDEX  <= '0;
            SET_BUFFER <= 1'b0;
            READY      <= 1'b1;
            FRAME_DONE <= 1'b0;
`ifdef READOUT_TIMEOUT_EN
            wd_cnt     <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            ROW_SELECT <= select_next;
            ROW_INDEX  <= index_next;
            SET_BUFFER <= set_next;
            READY      <= ready_next;
            FRAME_DONE <= done_next;
`ifdef READOUT_TIMEOUT_EN
            wd_cnt     <= wd_next;
            error_q    <= error_next;
`endif
        end
    end

endmodule

// File: tb/tb_readout_scheduler.sv
// Self-checking bench for readout_scheduler: timeline model plus directed frame scenarios.
module tb_readout_scheduler;

    localparam int unsigned H  = 2;
    localparam int unsigned S  = 1;
    localparam int unsigned B  = 4;
    localparam int unsigned AT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         busy;
    logic [H-1:0] row_select;
    logic [0:0]   row_index;
    logic         set_buffer;
    logic         ready;
    logic         frame_done;
    logic         error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int sb_cnt   = 0;
    int fd_cnt   = 0;
    bit cmp_en   = 0;

    readout_scheduler #(
        .PIXEL_ARRAY_HEIGHT(H),
        .SETTLE_CYCLES     (S),
        .BURST_CYCLES      (B),
        .ACK_TIMEOUT       (AT)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .START      (start),
        .ABORT      (abort),
        .BUFFER_BUSY(busy),
        .ROW_SELECT (row_select),
        .ROW_INDEX  (row_index),
        .SET_BUFFER (set_buffer),
        .READY      (ready),
        .FRAME_DONE (frame_done),
        .ERROR      (error)
    );

    always #5 clk = ~clk;

    // Output buffer: sees the strobe, raises busy one cycle later for busy_len cycles
    int   busy_len = 4;
    logic buf_en   = 1'b1;
    logic pend;
    int   bcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            bcnt <= 0;
        end else begin
            pend <= set_buffer & buf_en;
            if (pend)          bcnt <= busy_len;
            else if (bcnt != 0) bcnt <= bcnt - 1;
        end
    end
    assign busy = (bcnt != 0);

    // Timeline model: a running frame, its row, cycle age within the row, drain phase
    bit m_run, m_done, m_drain, m_err;
    int m_row, m_age, m_wait;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 0; m_done <= 0; m_drain <= 0; m_err <= 0;
            m_row <= 0; m_age <= 0; m_wait <= 0;
        end else if (abort && (m_run || m_done)) begin
            m_run  <= 0;
            m_done <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (!m_run) begin
            if (start && !abort) begin
                m_run <= 1; m_row <= 0; m_age <= 0; m_drain <= 0; m_err <= 0;
            end
        end else if (m_age <= int'(S)) begin
            m_age  <= m_age + 1;
            m_wait <= 0;
        end else if (!m_drain) begin
            if (busy) begin
                m_drain <= 1;
                m_wait  <= 0;
            end else begin
                m_wait <= m_wait + 1;
`ifdef READOUT_TIMEOUT_EN
                if (m_wait + 1 > int'(AT)) begin m_run <= 0; m_err <= 1; end
`endif
            end
        end else if (!busy) begin
            if (m_row == int'(H) - 1) begin
                m_run  <= 0;
                m_done <= 1;
            end else begin
                m_row   <= m_row + 1;
                m_age   <= 0;
                m_drain <= 0;
            end
        end else begin
            m_wait <= m_wait + 1;
`ifdef READOUT_TIMEOUT_EN
            if (m_wait + 1 > int'(B) + 2) begin m_run <= 0; m_err <= 1; end
`endif
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    // Per-cycle comparison against the model, plus pulse counting
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_row_select", int'(row_select), (m_run && !m_drain) ? (1 << m_row) : 0);
            chk("m_row_index",  int'(row_index),  m_row);
            chk("m_set_buffer", int'(set_buffer), int'(m_run && m_age == int'(S)));
            chk("m_ready",      int'(ready),      int'(!m_run && !m_done));
            chk("m_frame_done", int'(frame_done), int'(m_done));
            chk("m_error",      int'(error),      int'(m_err));
            chk("set_while_busy", int'(set_buffer & busy), 0);
            if (set_buffer) sb_cnt++;
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input int t0, input string name, input int exp_len);
        while (!frame_done && cyc - t0 < 60) tick();
        chk(name, cyc - t0, exp_len);
    endtask

    task automatic chk_reset_values();
        chk("rst_row_select", int'(row_select), 0);
        chk("rst_row_index",  int'(row_index),  0);
        chk("rst_set_buffer", int'(set_buffer), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_error",      int'(error),      0);
        chk("rst_ready",      int'(ready),      1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) tick();
        chk_reset_values();
        rst = 1'b0;
        cmp_en = 1;
        tick();

        // Single frame with the ideal buffer
        sb_cnt = 0; fd_cnt = 0;
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        chk("f1_sel_row0", int'(row_select), 1);
        chk("f1_idx_row0", int'(row_index), 0);
        chk("f1_ready_low", int'(ready), 0);
        tick();
        chk("f1_load0", int'(set_buffer), 1);
        tick();
        chk("f1_load0_end", int'(set_buffer), 0);
        chk("f1_ack_sel", int'(row_select), 1);
        repeat (2) tick();
        chk("f1_drain_sel", int'(row_select), 0);
        repeat (4) tick();
        chk("f1_sel_row1", int'(row_select), 2);
        chk("f1_idx_row1", int'(row_index), 1);
        wait_done(t0, "f1_done_at", 16);
        tick();
        chk("f1_ready_back", int'(ready), 1);
        chk("f1_done_pulse", int'(frame_done), 0);
        chk("f1_load_count", sb_cnt, 2);
        chk("f1_done_count", fd_cnt, 1);

        // START during row 0 drain is ignored
        fd_cnt = 0;
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        repeat (4) tick();
        chk("sb_drain_sel", int'(row_select), 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("sb_idx_kept", int'(row_index), 0);
        wait_done(t0, "sb_done_at", 16);
        repeat (10) tick();
        chk("sb_done_count", fd_cnt, 1);
        chk("sb_ready", int'(ready), 1);

        // ABORT while waiting for acknowledge, then restart
        fd_cnt = 0; buf_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        chk("ab_ack_sel", int'(row_select), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_sel_off", int'(row_select), 0);
        chk("ab_ready", int'(ready), 1);
        chk("ab_no_done", int'(frame_done), 0);
        buf_en = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        chk("ab_restart_idx", int'(row_index), 0);
        chk("ab_restart_sel", int'(row_select), 1);
        wait_done(t0, "ab_done_at", 16);
        tick();
        chk("ab_done_count", fd_cnt, 1);

        // START and ABORT together in IDLE
        sb_cnt = 0;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("sa_ready", int'(ready), 1);
        repeat (5) tick();
        chk("sa_no_load", sb_cnt, 0);

        // Asynchronous RESET during row 1 drain
        fd_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (12) tick();
        chk("rs_idx_row1", int'(row_index), 1);
        chk("rs_drain_sel", int'(row_select), 0);
        chk("rs_busy", int'(ready), 0);
        #2 rst = 1'b1;
        #1 chk_reset_values();
        tick(); tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("rs_no_done", fd_cnt, 0);
        chk("rs_ready", int'(ready), 1);

`ifdef READOUT_TIMEOUT_EN
        // Busy held too long: watchdog trips after 7 drain cycles
        fd_cnt = 0; busy_len = 10;
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        while (!error && cyc - t0 < 40) tick();
        chk("to_error_at", cyc - t0, 11);
        chk("to_ready", int'(ready), 1);
        chk("to_sel_off", int'(row_select), 0);
        repeat (5) tick();
        chk("to_error_sticky", int'(error), 1);
        chk("to_no_done", fd_cnt, 0);
        busy_len = 4;
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        chk("to_error_clear", int'(error), 0);
        wait_done(t0, "to_done_at", 16);
        tick();
`endif

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
